// File: rtl/conv5x5_mac_engine_pkg.sv
// Shared constants and requantisation helpers for the LeNet convolution datapath.
// Holds the tap/product/row-sum widths and the int8 rounding/saturation functions.
package lenet_pkg;

  localparam int K         = 5;
  localparam int IMG_W     = 32;
  localparam int OUT_W_DEF = IMG_W - K + 1;
  localparam int OUT_H_DEF = 28;
  localparam int PIX_W     = 8;
  localparam int PROD_W    = 16;
  localparam int ROW_W     = 19;
  localparam int ACC_W_DEF = 24;

  function automatic logic signed [7:0] sat_int8(input logic signed [32:0] v);
    if (v > 33'sd127) return 8'h7F;
    if (v < -33'sd128) return 8'h80;
    return v[7:0];
  endfunction

  // Round half up, arithmetic shift, optional ReLU, then clamp to int8.
  function automatic logic signed [7:0] requant(input logic signed [31:0] acc,
                                                input int shift,
                                                input logic relu);
    logic signed [32:0] y;
    y = 33'(acc);
    if (shift > 0) y = y + (33'sd1 <<< (shift - 1));
    y = y >>> shift;
    if (relu && y[32]) y = '0;
    return sat_int8(y);
  endfunction

endpackage

// File: rtl/conv5x5_mac_engine_row_dot5.sv
// One kernel row: five int8 taps times five int8 weights.
// Products are registered (S1), then summed into a registered 19-bit row sum (S2).
module conv_row_dot5
  import lenet_pkg::*;
(
  input  logic                    clk,
  input  logic                    en,
  input  logic [K*PIX_W-1:0]      taps,
  input  logic [K*PIX_W-1:0]      wgts,
  output logic signed [ROW_W-1:0] row_sum
);

  logic signed [PROD_W-1:0] prod [K];
  logic signed [ROW_W-1:0]  sum_next;

  for (genvar gi = 0; gi < K; gi++) begin : g_tap
    logic signed [PROD_W-1:0] prod_reg;
    always_ff @(posedge clk) begin
      if (en)
        prod_reg <= PROD_W'($signed(taps[gi*PIX_W +: PIX_W])) *
                    PROD_W'($signed(wgts[gi*PIX_W +: PIX_W]));
    end
    assign prod[gi] = prod_reg;
  end

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < K; i++) sum_next = sum_next + ROW_W'(prod[i]);
  end

  always_ff @(posedge clk) begin
    if (en) row_sum <= sum_next;
  end

endmodule

// File: rtl/conv5x5_mac_engine.sv
// 5x5 int8 convolution MAC engine: 4-stage stall-able pipeline with programmable
// weights/bias, requantisation to int8 and output row/column tracking.
module conv5x5_mac_engine
  import lenet_pkg::*;
#(
  parameter int OUT_W = 28,
  parameter int OUT_H = 28,
  parameter int ACC_W = 24,
  parameter int SHIFT = 7,
  parameter int RELU  = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_start,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [199:0] i_window,
  input  logic         i_row_start,
  input  logic         i_row_end,
  input  logic         i_wgt_we,
  input  logic [4:0]   i_wgt_addr,
  input  logic [7:0]   i_wgt_data,
  input  logic         i_bias_we,
  input  logic [15:0]  i_bias,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [7:0]   o_pixel,
  output logic         o_row_start,
  output logic         o_row_end,
  output logic [4:0]   o_col,
  output logic [4:0]   o_row,
  output logic         o_busy,
  output logic         o_wgt_err,
  output logic         o_done
);

  logic                     en, accept, hs, last_pix, wr_ok;
  logic signed [PIX_W-1:0]  wgt_reg [K*K];
  logic [K*K*PIX_W-1:0]     wgt_flat;
  logic signed [15:0]       bias_reg;
  logic [2:0]               vld_reg, rs_reg, re_reg;
  logic signed [ROW_W-1:0]  row_sum [K];
  logic signed [ACC_W-1:0]  acc_reg, acc_next;
  logic [4:0]               col_reg, row_reg;

  // One global enable: every stage advances together, bubbles included.
  assign en       = !o_valid || i_ready;
  assign o_ready  = en;
  assign accept   = i_valid && en && !i_start;
  assign hs       = o_valid && i_ready;
  assign last_pix = (col_reg == 5'(OUT_W - 1)) && (row_reg == 5'(OUT_H - 1));
  assign o_busy   = (|vld_reg) || o_valid;
  assign wr_ok    = !o_busy && en;
  assign o_col    = col_reg;
  assign o_row    = row_reg;

  for (genvar gi = 0; gi < K*K; gi++) begin : g_wflat
    assign wgt_flat[gi*PIX_W +: PIX_W] = wgt_reg[gi];
  end

  for (genvar gi = 0; gi < K; gi++) begin : g_row
    conv_row_dot5 u_row (
      .clk     (clk),
      .en      (en),
      .taps    (i_window[gi*K*PIX_W +: K*PIX_W]),
      .wgts    (wgt_flat[gi*K*PIX_W +: K*PIX_W]),
      .row_sum (row_sum[gi])
    );
  end

  // Writes land only with an empty pipeline, so no in-flight window sees a mix of weights.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < K*K; i++) wgt_reg[i] <= '0;
      bias_reg  <= '0;
      o_wgt_err <= 1'b0;
    end else begin
      o_wgt_err <= (i_wgt_we || i_bias_we) && !wr_ok;
      if (wr_ok && i_wgt_we && (i_wgt_addr < 5'(K*K))) wgt_reg[i_wgt_addr] <= i_wgt_data;
      if (wr_ok && i_bias_we) bias_reg <= i_bias;
    end
  end

  always_comb begin
    acc_next = ACC_W'(bias_reg);
    for (int r = 0; r < K; r++) acc_next = acc_next + ACC_W'(row_sum[r]);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      acc_reg <= acc_next;
      o_pixel <= requant(32'(acc_reg), SHIFT, RELU != 0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_reg     <= '0;
      rs_reg      <= '0;
      re_reg      <= '0;
      o_valid     <= 1'b0;
      o_row_start <= 1'b0;
      o_row_end   <= 1'b0;
      col_reg     <= '0;
      row_reg     <= '0;
      o_done      <= 1'b0;
    end else if (i_start) begin
      vld_reg <= '0;
      o_valid <= 1'b0;
      col_reg <= '0;
      row_reg <= '0;
      o_done  <= 1'b0;
    end else begin
      o_done <= hs && last_pix;
      if (en) begin
        vld_reg     <= {vld_reg[1:0], accept};
        rs_reg      <= {rs_reg[1:0], accept && i_row_start};
        re_reg      <= {re_reg[1:0], accept && i_row_end};
        o_valid     <= vld_reg[2];
        o_row_start <= rs_reg[2];
        o_row_end   <= re_reg[2];
      end
      if (hs) begin
        if (col_reg == 5'(OUT_W - 1)) begin
          col_reg <= '0;
          row_reg <= last_pix ? '0 : row_reg + 5'd1;
        end else begin
          col_reg <= col_reg + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv5x5_mac_engine.sv
// Directed bench: three engine instances share one stimulus stream and differ only in
// SHIFT/RELU, so one window exercises ReLU, saturation and rounding side by side.
module tb_conv5x5_mac_engine;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_start = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
  logic [199:0] i_window = '0;
  logic         i_row_start = 1'b0, i_row_end = 1'b0;
  logic         i_wgt_we = 1'b0, i_bias_we = 1'b0;
  logic [4:0]   i_wgt_addr = '0;
  logic [7:0]   i_wgt_data = '0;
  logic [15:0]  i_bias = '0;

  logic [2:0]   rdy, vld, ors, ore, busy, werr, done;
  logic [7:0]   pix [3];
  logic [4:0]   col [3];
  logic [4:0]   row [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: SHIFT 0, RELU 1. Instance 1: SHIFT 0, RELU 0. Instance 2: SHIFT 7, RELU 0.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    conv5x5_mac_engine #(
      .SHIFT (gi == 2 ? 7 : 0),
      .RELU  (gi == 0 ? 1 : 0)
    ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_start     (i_start),
      .i_valid     (i_valid),
      .o_ready     (rdy[gi]),
      .i_window    (i_window),
      .i_row_start (i_row_start),
      .i_row_end   (i_row_end),
      .i_wgt_we    (i_wgt_we),
      .i_wgt_addr  (i_wgt_addr),
      .i_wgt_data  (i_wgt_data),
      .i_bias_we   (i_bias_we),
      .i_bias      (i_bias),
      .o_valid     (vld[gi]),
      .i_ready     (i_ready),
      .o_pixel     (pix[gi]),
      .o_row_start (ors[gi]),
      .o_row_end   (ore[gi]),
      .o_col       (col[gi]),
      .o_row       (row[gi]),
      .o_busy      (busy[gi]),
      .o_wgt_err   (werr[gi]),
      .o_done      (done[gi])
    );
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [199:0] all_taps(input logic [7:0] v);
    return {25{v}};
  endfunction

  function automatic logic [199:0] centre(input logic [7:0] v);
    logic [199:0] w;
    w = '0;
    w[96 +: 8] = v;
    return w;
  endfunction

  task automatic do_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wr(input bit wwe, input logic [4:0] a, input logic [7:0] d,
                    input bit bwe, input logic [15:0] b);
    i_valid = 1'b0;
    i_wgt_we = wwe; i_wgt_addr = a; i_wgt_data = d;
    i_bias_we = bwe; i_bias = b;
    tick();
    i_wgt_we = 1'b0; i_bias_we = 1'b0;
    chk("wr_idle_no_err", werr[0], 0);
  endtask

  task automatic run_one(input string tag, input logic [199:0] w,
                         input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    int n;
    i_window = w; i_valid = 1'b1; i_ready = 1'b1;
    i_row_start = 1'b0; i_row_end = 1'b0;
    tick();
    i_valid = 1'b0;
    n = 1;
    while (!vld[0] && n < 20) begin tick(); n++; end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_relu1_sh0"}, pix[0], e0);
    chk({tag, "_relu0_sh0"}, pix[1], e1);
    chk({tag, "_relu0_sh7"}, pix[2], e2);
    tick();
  endtask

  task automatic run_frame(input string tag, input int stall_pct, input bit ramp);
    int sent, got, dones, first_acc, first_out, last_hs;
    logic [7:0] e;
    sent = 0; got = 0; dones = 0; first_acc = -1; first_out = -1; last_hs = -1;
    for (int t = 0; t < 8000; t++) begin
      i_ready     = ($urandom_range(99) >= stall_pct);
      i_valid     = (sent < 784);
      i_window    = ramp ? centre(8'(sent)) : all_taps(8'(sent));
      i_row_start = (sent % 28 == 0);
      i_row_end   = (sent % 28 == 27);
      #1;
      if (done[0]) begin
        dones++;
        chk({tag, "_done_after_last"}, t, last_hs + 1);
      end
      if (vld[0] && first_out < 0) first_out = t;
      if (vld[0] && i_ready) begin
        e = ramp ? 8'(got) : 8'd100;
        chk({tag, "_pix"}, pix[1], e);
        chk({tag, "_col"}, col[0], got % 28);
        chk({tag, "_row"}, row[0], got / 28);
        chk({tag, "_row_start"}, ors[0], (got % 28 == 0));
        chk({tag, "_row_end"}, ore[0], (got % 28 == 27));
        if (ramp) chk({tag, "_pix_relu"}, pix[0], e[7] ? 8'd0 : e);
        else      chk({tag, "_pix_sh7"}, pix[2], 8'd1);
        got++;
        if (got == 784) last_hs = t;
      end
      if (i_valid && rdy[0]) begin
        if (first_acc < 0) first_acc = t;
        sent++;
      end
      if (got == 784 && t > last_hs + 1) break;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    chk({tag, "_out_count"}, got, 784);
    chk({tag, "_done_count"}, dones, 1);
    if (stall_pct == 0) chk({tag, "_first_latency"}, first_out - first_acc, 4);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    chk("rst_valid", vld[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_wgt_err", werr[0], 0);
    chk("rst_col", col[0], 0);
    chk("rst_row", row[0], 0);
    run_one("rst_weights_zero", all_taps(8'd127), 8'd0, 8'd0, 8'd0);

    // Zero weights, bias 100: every pixel of the frame is the bias.
    wr(0, 5'd0, 8'd0, 1, 16'd100);
    do_start();
    run_frame("const_frame", 0, 1'b0);

    // Only the centre weight set; bias cleared in the same cycle.
    wr(1, 5'd12, 8'd1, 1, 16'd0);
    run_one("centre_neg5", centre(8'hFB), 8'd0, 8'hFB, 8'd0);

    for (int i = 0; i < 25; i++) wr(1, 5'(i), 8'd127, 0, 16'd0);
    run_one("sat_pos", all_taps(8'd127), 8'h7F, 8'h7F, 8'h7F);
    run_one("sat_neg", all_taps(8'h80), 8'd0, 8'h80, 8'h80);

    for (int i = 0; i < 25; i++) wr(1, 5'(i), 8'd0, 0, 16'd0);
    wr(1, 5'd25, 8'd9, 0, 16'd0);
    wr(0, 5'd0, 8'd0, 1, 16'd192);
    run_one("round_192", '0, 8'h7F, 8'h7F, 8'd2);
    wr(0, 5'd0, 8'd0, 1, 16'd191);
    run_one("round_191", '0, 8'h7F, 8'h7F, 8'd1);
    wr(0, 5'd0, 8'd0, 1, 16'hFF40);
    run_one("round_m192", '0, 8'd0, 8'h80, 8'hFF);

    // Pass-through of the centre tap under a 30% downstream stall rate.
    wr(1, 5'd12, 8'd1, 1, 16'd0);
    do_start();
    run_frame("stall_frame", 30, 1'b1);

    // Weight write while windows are in flight must be refused.
    do_start();
    i_ready = 1'b1; i_valid = 1'b1; i_window = centre(8'd2);
    tick();
    tick();
    i_valid = 1'b0;
    i_wgt_we = 1'b1; i_wgt_addr = 5'd12; i_wgt_data = 8'd5;
    tick();
    i_wgt_we = 1'b0;
    chk("busy_wgt_err", werr[0], 1);
    tick();
    chk("wgt_err_pulse_end", werr[0], 0);
    repeat (6) tick();
    chk("drained_idle", busy[0], 0);
    run_one("wgt_kept", centre(8'd3), 8'd3, 8'd3, 8'd0);

    // i_start mid-stream flushes the pipeline and the position counters.
    do_start();
    i_ready = 1'b1; i_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      i_window = centre(8'(k));
      tick();
    end
    chk("mid_col_moved", col[0], 8);
    i_start = 1'b1; i_window = centre(8'd9);
    tick();
    i_start = 1'b0; i_valid = 1'b0;
    chk("start_valid_drop", vld[0], 0);
    chk("start_col", col[0], 0);
    chk("start_row", row[0], 0);
    tick();
    chk("start_flushed", busy[0], 0);
    i_valid = 1'b1; i_window = centre(8'd7);
    tick();
    i_valid = 1'b0;
    n = 1;
    while (!vld[0] && n < 20) begin tick(); n++; end
    chk("after_start_lat", n, 4);
    chk("after_start_pix", pix[1], 8'd7);
    chk("after_start_col", col[0], 0);
    chk("after_start_row", row[0], 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
